// File: rtl/prio_stream_arbiter.sv
// Event-based stream arbiter that picks which memory block streams next into the output mux.
// Each block is granted at most once per event. Fixed priority or round-robin order; empty blocks are skipped.
module prio_stream_arbiter #(
    parameter int NCH  = 12,
    parameter int SELW = 4,
    parameter int RR   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NCH-1:0]  has_dat,
    input  logic            done,
    output logic [NCH-1:0]  sel_onehot,
    output logic [SELW-1:0] sel,
    output logic            valid,
    output logic            none,
    output logic            busy,
    output logic [1:0]      dbg_state
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MARK = 2'd1,
        S_ARB  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [NCH-1:0]  r_served;
    logic [NCH-1:0]  r_onehot;
    logic [NCH-1:0]  w_onehot_n;
    logic [NCH-1:0]  w_elig;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] w_sel_n;
    logic            r_valid;
    logic            r_none;
    logic            r_busy;
    logic            w_valid_n;
    logic            w_none_n;
    logic            w_busy_n;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_ptr_n;
    logic [IW:0]     w_idx;
    logic            w_found;
    logic            w_grant;

    assign w_elig = has_dat & ~r_served;

    // Scan candidates in priority order; in round-robin the scan starts at the pointer and wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = (RR != 0) ? ({1'b0, r_ptr} + (IW+1)'(k)) : (IW+1)'(k);
            if (w_idx >= (IW+1)'(NCH)) begin
                w_idx = w_idx - (IW+1)'(NCH);
            end
            if (!w_found && w_elig[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    assign w_ptr_n = (w_win == IW'(NCH-1)) ? '0 : (w_win + IW'(1));
    assign w_grant = (r_state == S_ARB) && !start && w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // start takes precedence over done in every state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_MARK;
            S_MARK:  w_next_state = start ? S_MARK : S_ARB;
            S_ARB:   w_next_state = start ? S_MARK : (w_found ? S_HOLD : S_IDLE);
            S_HOLD:  w_next_state = start ? S_MARK : (done ? S_ARB : S_HOLD);
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_n    = '0;
        w_onehot_n = '0;
        w_valid_n  = 1'b0;
        w_none_n   = 1'b0;
        w_busy_n   = (w_next_state != S_IDLE);
        case (w_next_state)
            S_MARK: w_sel_n = '1;
            S_HOLD: begin
                if (w_grant) begin
                    w_onehot_n = NCH'(1) << w_win;
                    w_sel_n    = SELW'(w_win) + SELW'(1);
                    w_valid_n  = 1'b1;
                end else begin
                    w_onehot_n = r_onehot;
                    w_sel_n    = r_sel;
                    w_valid_n  = r_valid;
                end
            end
            S_IDLE: w_none_n = (r_state == S_ARB);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_none   <= 1'b0;
            r_busy   <= 1'b0;
            r_served <= '0;
            r_ptr    <= '0;
        end else begin
            r_sel    <= w_sel_n;
            r_onehot <= w_onehot_n;
            r_valid  <= w_valid_n;
            r_none   <= w_none_n;
            r_busy   <= w_busy_n;
            if (w_next_state == S_MARK) begin
                r_served <= '0;
            end else if (w_grant) begin
                r_served[w_win] <= 1'b1;
                r_ptr           <= w_ptr_n;
            end
        end
    end

    assign sel        = r_sel;
    assign sel_onehot = r_onehot;
    assign valid      = r_valid;
    assign none       = r_none;
    assign busy       = r_busy;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_prio_stream_arbiter.sv
// Bench for prio_stream_arbiter: one fixed-priority and one round-robin instance, driven one at a time,
// with expected marker/grant/none events queued by the driver and popped by a negedge monitor.
module tb_prio_stream_arbiter;
    localparam int NCH  = 12;
    localparam int SELW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_v [2];
    logic            done_v  [2];
    logic [NCH-1:0]  has_v   [2];
    logic [NCH-1:0]  oh_v    [2];
    logic [SELW-1:0] sel_v   [2];
    logic            valid_v [2];
    logic            none_v  [2];
    logic            busy_v  [2];
    logic [1:0]      st_v    [2];

    logic [7:0] exp_q[$];
    int         ptr_m [2];
    bit         prev_valid [2];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    prio_stream_arbiter #(.NCH(NCH), .SELW(SELW), .RR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .has_dat(has_v[0]), .done(done_v[0]),
        .sel_onehot(oh_v[0]), .sel(sel_v[0]), .valid(valid_v[0]), .none(none_v[0]),
        .busy(busy_v[0]), .dbg_state(st_v[0])
    );

    prio_stream_arbiter #(.NCH(NCH), .SELW(SELW), .RR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .has_dat(has_v[1]), .done(done_v[1]),
        .sel_onehot(oh_v[1]), .sel(sel_v[1]), .valid(valid_v[1]), .none(none_v[1]),
        .busy(busy_v[1]), .dbg_state(st_v[1])
    );

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] code(input int d, input int v);
        return 8'((d << 6) | v);
    endfunction

    // Reference choice: first non-empty, not yet served block in scan order.
    function automatic int pick(input logic [NCH-1:0] elig, input int ptr, input bit rr);
        for (int k = 0; k < NCH; k++) begin
            int i;
            i = rr ? (ptr + k) % NCH : k;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: every marker, rising valid and none pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid[0] = 1'b0;
            prev_valid[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] got;
                bit ev;
                ev = 1'b0;
                got = '0;
                if (sel_v[d] == 4'hF || sel_v[d] == 4'h0)
                    chk("onehot_zero", int'(oh_v[d]), 0);
                else
                    chk("onehot_match", int'(oh_v[d]), 1 << (int'(sel_v[d]) - 1));
                chk("valid_vs_sel", int'(valid_v[d]), int'(sel_v[d] != 4'h0 && sel_v[d] != 4'hF));
                if (sel_v[d] == 4'hF) begin
                    ev = 1'b1;
                    got = code(d, 15);
                end else if (valid_v[d] && !prev_valid[d]) begin
                    ev = 1'b1;
                    got = code(d, int'(sel_v[d]));
                end else if (none_v[d]) begin
                    ev = 1'b1;
                    got = code(d, 8'h80);
                end
                if (ev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", int'(got), -1);
                    end else begin
                        chk("event_code", int'(got), int'(exp_q.pop_front()));
                    end
                end
                prev_valid[d] = valid_v[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (valid_v[d]) ok = 1'b1;
            else tick();
        end
        chk("grant_timeout", int'(ok), 1);
    endtask

    task automatic wait_none(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (none_v[d]) seen = 1'b1;
        end
        chk("none_seen", int'(seen), 1);
        chk("none_busy", int'(busy_v[d]), 0);
        tick();
        chk("none_one_cycle", int'(none_v[d]), 0);
        chk("idle_busy", int'(busy_v[d]), 0);
    endtask

    // One event on instance d; restart_k re-issues start (with done) during that grant's hold.
    task automatic run_event(input int d, input logic [NCH-1:0] has, input int restart_k, input int hold_n);
        logic [NCH-1:0] served;
        int  w;
        int  ng;
        int  h;
        bit  ok;
        bit  restarted;
        served = '0;
        ng = 0;
        restarted = 1'b0;
        has_v[d] = has;
        exp_q.push_back(code(d, 15));
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        while (ng < 2 * NCH + 2) begin
            w = pick(has & ~served, ptr_m[d], d == 1);
            if (w < 0) begin
                exp_q.push_back(code(d, 8'h80));
                wait_none(d);
                break;
            end
            exp_q.push_back(code(d, w + 1));
            served[w] = 1'b1;
            ptr_m[d] = (w + 1) % NCH;
            wait_valid(d, ok);
            if (!ok) break;
            h = (hold_n < 0) ? $urandom_range(0, 6) : hold_n;
            for (int c = 0; c < h; c++) begin
                has_v[d] = NCH'($urandom);
                tick();
                chk("hold_sel", int'(sel_v[d]), w + 1);
                chk("hold_onehot", int'(oh_v[d]), 1 << w);
                chk("hold_valid", int'(valid_v[d]), 1);
            end
            has_v[d] = has;
            if (ng == restart_k && !restarted) begin
                restarted = 1'b1;
                exp_q.push_back(code(d, 15));
                start_v[d] = 1'b1;
                done_v[d] = 1'b1;
                tick();
                start_v[d] = 1'b0;
                done_v[d] = 1'b0;
                served = '0;
            end else begin
                done_v[d] = 1'b1;
                tick();
                done_v[d] = 1'b0;
            end
            ng++;
        end
        chk("event_bounded", int'(ng < 2 * NCH + 2), 1);
    endtask

    task automatic check_idle(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_sel"}, int'(sel_v[d]), 0);
            chk({nm, "_onehot"}, int'(oh_v[d]), 0);
            chk({nm, "_valid"}, int'(valid_v[d]), 0);
            chk({nm, "_none"}, int'(none_v[d]), 0);
            chk({nm, "_busy"}, int'(busy_v[d]), 0);
        end
    endtask

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            done_v[d] = 1'b0;
            has_v[d] = '0;
            ptr_m[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        run_event(0, 12'h824, -1, 20);
        run_event(0, 12'h000, -1, 2);

        done_v[0] = 1'b1;
        tick();
        done_v[0] = 1'b0;
        repeat (3) begin
            tick();
            check_idle("done_in_idle");
        end

        run_event(0, 12'h018, 0, 2);

        run_event(1, 12'h400, -1, 1);
        run_event(1, 12'hC01, -1, 3);

        for (int n = 0; n < 40; n++) begin
            int d;
            logic [NCH-1:0] has;
            int rk;
            d = n % 2;
            has = ($urandom_range(0, 1) == 0) ? NCH'($urandom) : NCH'($urandom & $urandom);
            rk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
            run_event(d, has, rk, -1);
            repeat ($urandom_range(0, 3)) tick();
        end

        has_v[0] = 12'h010;
        exp_q.push_back(code(0, 15));
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        exp_q.push_back(code(0, 5));
        wait_valid(0, ok);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        #3;
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check_idle("after_reset");
        end

        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
